// File: rtl/ndro_bank_if.sv
// Strobe/observation bundle for the ndro_bank NDRO cell bank.
interface ndro_bank_if #(parameter int N = 4);
   logic [N-1:0] set;
   logic [N-1:0] clr;
   logic         clk_rd;
   logic [N-1:0] out;
   logic [N-1:0] state;
   logic         ready;
   logic [N-1:0] viol;
   logic         err;

   modport master (output set, clr, clk_rd, input out, state, ready, viol, err);
   modport slave  (input set, clr, clk_rd, output out, state, ready, viol, err);
endinterface

// File: rtl/ndro_bank.sv
// N-channel NDRO cell bank: set/clr stored bits, shared non-destructive readout with
// edge-encoded outputs. Hold-window checkers present when NDRO_BANK_TIMING_CHECK_EN is defined.
module ndro_bank #(
   parameter int N         = 4,
   parameter int READ_LAT  = 2,
   parameter int HOLD_CYC  = 2,
   parameter int START_CYC = 8
) (
   input logic        clk,
   input logic        reset,
   ndro_bank_if.slave bus
);
   logic [7:0]   start_cnt;
   logic         ready_q;
   logic [N-1:0] state_q;
   logic [N-1:0] out_q;
   logic [N-1:0] set_a, clr_a;
   logic         rd_a;
   logic [READ_LAT-1:0][N-1:0] rd_pipe;

   // Strobes are dropped entirely until the startup period has elapsed.
   assign set_a = bus.set & {N{ready_q}};
   assign clr_a = bus.clr & {N{ready_q}};
   assign rd_a  = bus.clk_rd & ready_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         start_cnt <= '0;
         ready_q   <= (START_CYC == 0);
      end else if (!ready_q) begin
         start_cnt <= start_cnt + 8'd1;
         if ({1'b0, start_cnt} + 9'd1 >= 9'(START_CYC)) ready_q <= 1'b1;
      end
   end

   // set&clr together leaves the bit untouched.
   always_ff @(posedge clk) begin
      if (reset) state_q <= '0;
      else       state_q <= (state_q | (set_a & ~clr_a)) & ~(clr_a & ~set_a);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pipe <= '0;
         out_q   <= '0;
      end else begin
         rd_pipe[0] <= rd_a ? state_q : '0;
         for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
         out_q <= out_q ^ rd_pipe[READ_LAT-1];
      end
   end

   assign bus.state = state_q;
   assign bus.out   = out_q;
   assign bus.ready = ready_q;

`ifdef NDRO_BANK_TIMING_CHECK_EN
   logic [N-1:0] hit;
   logic [N-1:0] viol_q;
   logic         err_q;

   for (genvar i = 0; i < N; i++) begin : g_chk
      logic [3:0] since_clr, since_rd;

      // Counters hold HOLD_CYC when no recent event; below it means still inside the window.
      assign hit[i] = (set_a[i] & (clr_a[i] | (since_clr < 4'(HOLD_CYC)))) |
                      (clr_a[i] & ((rd_a & state_q[i]) | (since_rd < 4'(HOLD_CYC))));

      always_ff @(posedge clk) begin
         if (reset) begin
            since_clr <= 4'(HOLD_CYC);
            since_rd  <= 4'(HOLD_CYC);
         end else begin
            if (clr_a[i])                       since_clr <= '0;
            else if (since_clr < 4'(HOLD_CYC)) since_clr <= since_clr + 4'd1;
            if (rd_a & state_q[i])              since_rd  <= '0;
            else if (since_rd < 4'(HOLD_CYC))  since_rd  <= since_rd + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         viol_q <= '0;
         err_q  <= 1'b0;
      end else begin
         viol_q <= viol_q | hit;
         err_q  <= |viol_q;
      end
   end

   assign bus.viol = viol_q;
   assign bus.err  = err_q;
`else
   assign bus.viol = '0;
   assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_ndro_bank.sv
// Directed + randomized bench for ndro_bank against a timestamp-based reference model.
module tb_ndro_bank;
   localparam int N = 4, L = 2, H = 2, S = 8;
`ifdef NDRO_BANK_TIMING_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1;
   ndro_bank_if #(.N(N)) bus();
   ndro_bank #(.N(N), .READ_LAT(L), .HOLD_CYC(H), .START_CYC(S)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct { int due; logic [N-1:0] v; } pend_t;
   pend_t        pend[$];
   logic [N-1:0] m_state, m_out, m_viol;
   logic         m_err, m_ready;
   int           edges;
   int           last_clr[N], last_rd[N];
   int           checks = 0, failures = 0;

   // Reference: readouts are timestamped and fire at edge+L; hold windows are distances between timestamps.
   task automatic model_edge(input logic rs, input logic [N-1:0] s, input logic [N-1:0] c, input logic r);
      logic new_err;
      if (rs) begin
         m_state = '0; m_out = '0; m_viol = '0; m_err = 1'b0;
         m_ready = (S == 0); edges = 0; pend.delete();
         for (int i = 0; i < N; i++) begin last_clr[i] = -100; last_rd[i] = -100; end
      end else begin
         edges++;
         new_err = |m_viol;
         if (m_ready) begin
            for (int i = 0; i < N; i++) begin
               if (CHK && s[i] && (c[i] || edges - last_clr[i] <= H)) m_viol[i] = 1'b1;
               if (CHK && c[i] && ((r && m_state[i]) || edges - last_rd[i] <= H)) m_viol[i] = 1'b1;
            end
            if (r) pend.push_back('{edges + L, m_state});
            for (int i = 0; i < N; i++) begin
               if (c[i]) last_clr[i] = edges;
               if (r && m_state[i]) last_rd[i] = edges;
               if (s[i] && !c[i]) m_state[i] = 1'b1;
               if (c[i] && !s[i]) m_state[i] = 1'b0;
            end
         end
         while (pend.size() > 0 && pend[0].due == edges) begin
            m_out = m_out ^ pend[0].v;
            void'(pend.pop_front());
         end
         m_err   = new_err;
         m_ready = (edges >= S);
      end
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%b exp=%b at edge %0d", tag, obs, exp, edges);
      end
   endtask

   task automatic tick(input logic rs, input logic [N-1:0] s, input logic [N-1:0] c, input logic r);
      reset = rs; bus.set = s; bus.clr = c; bus.clk_rd = r;
      @(posedge clk);
      model_edge(rs, s, c, r);
      #1;
      chk("state", bus.state, m_state);
      chk("out",   bus.out,   m_out);
      chk("ready", N'(bus.ready), N'(m_ready));
      chk("viol",  bus.viol,  m_viol);
      chk("err",   N'(bus.err), N'(m_err));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, '0, '0, 1'b0);
   endtask

   task automatic boot;
      tick(1'b1, '0, '0, 1'b0);
      idle(S);
      tick(1'b0, 4'b1111, '0, 1'b0);   // edge S+1: cells now load
   endtask

   initial begin
      bus.set = '0; bus.clr = '0; bus.clk_rd = 1'b0;
      // Startup gating
      tick(1'b1, '0, '0, 1'b0);
      chk("rst_state", bus.state, 4'b0000);
      chk("rst_ready", N'(bus.ready), 4'b0000);
      idle(2);
      tick(1'b0, 4'b1111, '0, 1'b0);
      chk("early_set", bus.state, 4'b0000);
      idle(S - 4);
      chk("pre_ready", N'(bus.ready), 4'b0000);
      idle(1);
      chk("ready_up", N'(bus.ready), 4'b0001);
      tick(1'b0, 4'b1111, '0, 1'b0);
      chk("set_all", bus.state, 4'b1111);

      // Readout latency and back-to-back toggles
      tick(1'b0, '0, 4'b1010, 1'b0);
      idle(3);
      tick(1'b0, '0, '0, 1'b1);
      tick(1'b0, '0, '0, 1'b1);
      chk("rd_t1", bus.out, 4'b0000);
      idle(1);
      chk("rd_t2", bus.out, 4'b0101);
      idle(1);
      chk("rd_t3", bus.out, 4'b0000);
      chk("rd_keep", bus.state, 4'b0101);

      // Set/clear semantics
      idle(3);
      tick(1'b0, 4'b0001, '0, 1'b0);
      tick(1'b0, '0, 4'b0010, 1'b0);
      chk("ignored", bus.state, 4'b0101);
      tick(1'b0, 4'b0100, 4'b0100, 1'b0);
      chk("setclr_st", bus.state, 4'b0101);
      chk("setclr_v", bus.viol, CHK ? 4'b0100 : 4'b0000);

      // clr -> set at distance 2: flagged
      boot();
      idle(2);
      tick(1'b0, '0, 4'b0001, 1'b0);
      idle(1);
      tick(1'b0, 4'b0001, '0, 1'b0);
      chk("hold_v0", bus.viol, CHK ? 4'b0001 : 4'b0000);
      idle(1);
      chk("hold_err", N'(bus.err), CHK ? 4'b0001 : 4'b0000);

      // clr -> set at distance 3: clean; read-then-clr flagged
      boot();
      idle(2);
      tick(1'b0, '0, 4'b0001, 1'b0);
      idle(2);
      tick(1'b0, 4'b0001, '0, 1'b0);
      chk("hold_ok", bus.viol, 4'b0000);
      idle(3);
      tick(1'b0, '0, '0, 1'b1);
      tick(1'b0, '0, 4'b0010, 1'b0);
      chk("rd_clr_v", bus.viol, CHK ? 4'b0010 : 4'b0000);

      // Reset with a readout in flight
      boot();
      idle(1);
      tick(1'b0, '0, '0, 1'b1);
      tick(1'b1, '0, '0, 1'b0);
      idle(L + 2);
      chk("mid_out", bus.out, 4'b0000);
      chk("mid_state", bus.state, 4'b0000);

      // Randomized traffic
      boot();
      for (int k = 0; k < 400; k++) begin
         logic [N-1:0] s, c;
         s = '0; c = '0;
         for (int i = 0; i < N; i++) begin
            s[i] = ($urandom_range(0, 5) == 0);
            c[i] = ($urandom_range(0, 5) == 0);
         end
         tick(($urandom_range(0, 99) == 0), s, c, ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
